alu_ror_seq: RTL

- Multi-cycle rotate-right unit for the MiniSRC ALU datapath. It is the right-rotate counterpart of the combinational rotate-left unit.
- Captures an operand and a rotate count on a start pulse. It then rotates by successive power-of-two strides, one set bit of the count per cycle, highest set bit first.
- Results appear on a registered output with a one-cycle done pulse. The control unit can overlap other micro-steps while busy is high.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_ror_step.sv | 30 +++
 rtl/alu_ror_seq.sv | 113 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the MiniSRC ALU rotate units: operand geometry,
// the sequencer state encoding and a highest-set-bit helper.
package alu_pkg;

  // Operand width; must be a power of two.
  localparam int WIDTH    = 32;
  // log2(WIDTH): width of the effective rotate count and of a stage index.
  localparam int CNT_BITS = 5;

  // Sequencer states for the multi-cycle rotate.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Index of the most significant set bit of v; returns 0 when v is 0.
  // The loop walks upward so the last set bit seen is the highest one.
  function automatic logic [CNT_BITS-1:0] hsb(input logic [CNT_BITS-1:0] v);
    logic [CNT_BITS-1:0] idx;
    idx = '0;
    for (int i = 0; i < CNT_BITS; i++) begin
      if (v[i]) idx = CNT_BITS'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/alu_ror_step.sv
// One rotate stride: value rotated right by 2^k. Each legal k has its own
// fixed wiring (a concatenation), and k simply selects among them.
module alu_ror_step #(
  parameter int WIDTH    = alu_pkg::WIDTH,
  parameter int CNT_BITS = alu_pkg::CNT_BITS
) (
  input  logic [WIDTH-1:0]    value,
  input  logic [CNT_BITS-1:0] k,
  output logic [WIDTH-1:0]    rotated
);

  // stage[g] is value rotated right by 2^g: the low 2^g bits wrap to the top.
  logic [WIDTH-1:0] stage [CNT_BITS];

  for (genvar g = 0; g < CNT_BITS; g++) begin : g_stage
    localparam int S = 1 << g;
    assign stage[g] = {value[S-1:0], value[WIDTH-1:S]};
  end

  // Select the stride for k; out-of-range k passes the value through.
  always_comb begin
    // NOTE: assigning a default before the selection keeps this purely
    // combinational; a path that left rotated unassigned would infer a latch.
    rotated = value;
    for (int i = 0; i < CNT_BITS; i++) begin
      if (k == CNT_BITS'(i)) rotated = stage[i];
    end
  end

endmodule

// File: rtl/alu_ror_seq.sv
// Multi-cycle rotate-right unit. A start pulse captures the operand and the
// count mod WIDTH; each following cycle applies the stride of the highest
// remaining count bit, and the result lands in data_output with a done pulse.
module alu_ror_seq #(
  parameter int WIDTH    = alu_pkg::WIDTH,
  parameter int CNT_BITS = alu_pkg::CNT_BITS
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] data_input,
  input  logic [31:0]      num_rotates,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_output
);

  import alu_pkg::state_t;
  import alu_pkg::IDLE;
  import alu_pkg::ROTATE;
  import alu_pkg::DONE;
  import alu_pkg::hsb;

  state_t              state, state_nxt;
  logic [WIDTH-1:0]    opnd, opnd_nxt;
  logic [CNT_BITS-1:0] rem, rem_nxt;
  logic [WIDTH-1:0]    result_nxt;
  logic [CNT_BITS-1:0] k;
  logic [CNT_BITS-1:0] rem_cleared;
  logic [WIDTH-1:0]    rotated;

  // Count bits above log2(WIDTH) are whole turns and never affect the result.
  logic unused_hi_count;
  assign unused_hi_count = ^num_rotates[31:CNT_BITS];

  // Largest stride still owed, and the count with that stride retired.
  always_comb begin
    k              = hsb(rem);
    rem_cleared    = rem;
    rem_cleared[k] = 1'b0;
  end

  alu_ror_step #(
    .WIDTH    (WIDTH),
    .CNT_BITS (CNT_BITS)
  ) u_step (
    .value   (opnd),
    .k       (k),
    .rotated (rotated)
  );

  // Next-state and next-register values; everything holds unless changed.
  always_comb begin
    state_nxt  = state;
    opnd_nxt   = opnd;
    rem_nxt    = rem;
    result_nxt = data_output;
    unique case (state)
      IDLE: begin
        if (start) begin
          opnd_nxt = data_input;
          rem_nxt  = num_rotates[CNT_BITS-1:0];
          if (num_rotates[CNT_BITS-1:0] == '0) begin
            // Zero effective count: the operand is already the answer.
            result_nxt = data_input;
            state_nxt  = DONE;
          end else begin
            state_nxt = ROTATE;
          end
        end
      end
      ROTATE: begin
        opnd_nxt = rotated;
        rem_nxt  = rem_cleared;
        if (rem_cleared == '0) begin
          result_nxt = rotated;
          state_nxt  = DONE;
        end
      end
      DONE: begin
        // Single done cycle; start is not sampled here, so nothing queues.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, working registers and result; clear wins over everything.
  always_ff @(posedge clock) begin
    // NOTE: operand and count registers are reset along with the FSM so an
    // aborted operation leaves no stale data behind after clear.
    if (clear) begin
      state       <= IDLE;
      opnd        <= '0;
      rem         <= '0;
      data_output <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the pre-edge state, independent of statement order.
      state       <= state_nxt;
      opnd        <= opnd_nxt;
      rem         <= rem_nxt;
      data_output <= result_nxt;
    end
  end

  // Status flags decode the state register only; start has no path here.
  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
